// File: rtl/gate_exerciser.sv
// Sequential exerciser for 3-input gate blocks: walks all eight {a,b,c} vectors,
// samples the DUT output at the end of each hold window and tallies mismatches.
module gate_exerciser #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] func_sel,
   input  logic       dut_y,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] first_err_vec
);

   // state   | meaning
   // S_IDLE  | waiting for start, a/b/c parked at 000
   // S_DRIVE | holding vector r_vec, sample on last hold cycle
   // S_DONE  | one-cycle done pulse, then back to idle
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     r_state, w_state_nxt;
   logic [2:0] r_vec, w_vec_nxt;
   logic [7:0] r_hold, w_hold_nxt;
   logic [1:0] r_func, w_func_nxt;
   logic [3:0] r_err, w_err_nxt;
   logic [2:0] r_first, w_first_nxt;
   logic [2:0] r_abc, w_abc_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_done, w_done_nxt;
   logic       r_pass, w_pass_nxt;

   logic       w_exp;
   logic       w_mis;
   logic [3:0] w_err_upd;

   always_comb begin
      case (r_func)
         2'b00:   w_exp = &r_vec;
         2'b01:   w_exp = |r_vec;
         2'b10:   w_exp = ^r_vec;
         default: w_exp = ~(|r_vec);
      endcase
   end

   assign w_mis     = dut_y ^ w_exp;
   assign w_err_upd = r_err + {3'b000, w_mis};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_vec   <= 3'd0;
         r_hold  <= 8'd0;
         r_func  <= 2'd0;
         r_err   <= 4'd0;
         r_first <= 3'd0;
         r_abc   <= 3'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_vec   <= w_vec_nxt;
         r_hold  <= w_hold_nxt;
         r_func  <= w_func_nxt;
         r_err   <= w_err_nxt;
         r_first <= w_first_nxt;
         r_abc   <= w_abc_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_pass  <= w_pass_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_vec_nxt   = r_vec;
      w_hold_nxt  = r_hold;
      w_func_nxt  = r_func;
      w_err_nxt   = r_err;
      w_first_nxt = r_first;
      w_abc_nxt   = r_abc;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_pass_nxt  = r_pass;

      case (r_state)
         S_IDLE: begin
            w_abc_nxt  = 3'd0;
            w_busy_nxt = 1'b0;
            if (start) begin
               w_func_nxt  = func_sel;
               w_vec_nxt   = 3'd0;
               w_hold_nxt  = 8'd0;
               w_err_nxt   = 4'd0;
               w_first_nxt = 3'd0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_DRIVE;
            end
         end

         S_DRIVE: begin
            w_hold_nxt = r_hold + 8'd1;
            if (r_hold == HOLD_LAST) begin
               w_err_nxt = w_err_upd;
               if (w_mis && (r_err == 4'd0)) begin
                  w_first_nxt = r_vec;
               end
               if (r_vec == 3'd7) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                  w_busy_nxt  = 1'b0;
                  w_abc_nxt   = 3'd0;
                  w_pass_nxt  = (w_err_upd == 4'd0);
               end else begin
                  w_vec_nxt  = r_vec + 3'd1;
                  w_hold_nxt = 8'd0;
                  w_abc_nxt  = r_vec + 3'd1;
               end
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign {a, b, c}     = r_abc;
   assign busy          = r_busy;
   assign done          = r_done;
   assign pass          = r_pass;
   assign err_count     = r_err;
   assign first_err_vec = r_first;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: a behavioural gate model feeds dut_y, and per-run
// expected results are queued at start and checked when done pulses.
module tb_gate_exerciser;

   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] func_sel;
   logic       dut_y;
   logic       a, b, c;
   logic       busy, done, pass;
   logic [3:0] err_count;
   logic [2:0] first_err_vec;

   int n_checks = 0;
   int n_fail   = 0;
   int mode     = 1;
   int done_cnt = 0;

   typedef struct {
      logic [3:0] err;
      logic [2:0] first;
      logic       pass;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   gate_exerciser #(.HOLD_CYCLES(H)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .func_sel      (func_sel),
      .dut_y         (dut_y),
      .a             (a),
      .b             (b),
      .c             (c),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_vec (first_err_vec)
   );

   function automatic logic ref_fn(input logic [1:0] f, input logic [2:0] v);
      case (f)
         2'b00:   return v[2] & v[1] & v[0];
         2'b01:   return v[2] | v[1] | v[0];
         2'b10:   return v[2] ^ v[1] ^ v[0];
         default: return ~(v[2] | v[1] | v[0]);
      endcase
   endfunction

   // modes: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 stuck-0, 5 stuck-1, 6 XOR with c open
   function automatic logic dut_fn(input int m, input logic [2:0] v);
      case (m)
         0:       return v[2] & v[1] & v[0];
         1:       return v[2] | v[1] | v[0];
         2:       return v[2] ^ v[1] ^ v[0];
         3:       return ~(v[2] | v[1] | v[0]);
         4:       return 1'b0;
         5:       return 1'b1;
         default: return v[2] ^ v[1];
      endcase
   endfunction

   always_comb dut_y = dut_fn(mode, {a, b, c});

   always @(posedge clk) if (done) done_cnt++;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Calls begin and end #1 after a clock edge with the DUT idle-ready.
   task automatic run(input logic [1:0] f, input int m, input bit disturb);
      exp_t e;
      int   dc0;
      e.err   = 4'd0;
      e.first = 3'd0;
      for (int v = 0; v < 8; v++) begin
         if (dut_fn(m, 3'(v)) != ref_fn(f, 3'(v))) begin
            if (e.err == 4'd0) e.first = 3'(v);
            e.err = e.err + 4'd1;
         end
      end
      e.pass = (e.err == 4'd0);
      sb_q.push_back(e);

      mode     = m;
      func_sel = f;
      start    = 1'b1;
      tick();
      start = 1'b0;
      dc0   = done_cnt;
      for (int o = 0; o < 8 * H; o++) begin
         if (o % H == 0) chk("vec", 8'({a, b, c}), 8'(o / H));
         if (o == 1) chk("busy_run", 8'(busy), 8'd1);
         if (disturb && o == 2) begin
            start    = 1'b1;
            func_sel = 2'b10;
         end
         if (disturb && o == 3) start = 1'b0;
         tick();
      end
      chk("done_hi", 8'(done), 8'd1);
      chk("busy_end", 8'(busy), 8'd0);
      chk("abc_end", 8'({a, b, c}), 8'd0);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 8'd1, 8'd0);
      end else begin
         e = sb_q.pop_front();
         chk("err_count", 8'(err_count), 8'(e.err));
         chk("first_err_vec", 8'(first_err_vec), 8'(e.first));
         chk("pass", 8'(pass), 8'(e.pass));
      end
      tick();
      chk("done_lo", 8'(done), 8'd0);
      chk("done_pulses", 8'(done_cnt - dc0), 8'd1);
   endtask

   initial begin
      int dc0;
      rst_n    = 1'b0;
      start    = 1'b0;
      func_sel = 2'b00;
      tick();
      tick();
      chk("rst_abc", 8'({a, b, c}), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_done", 8'(done), 8'd0);
      chk("rst_pass", 8'(pass), 8'd0);
      chk("rst_err", 8'(err_count), 8'd0);
      chk("rst_first", 8'(first_err_vec), 8'd0);
      rst_n = 1'b1;
      tick();

      run(2'b01, 1, 1'b0);
      repeat (3) tick();
      chk("idle_pass", 8'(pass), 8'd1);

      run(2'b01, 4, 1'b0);
      repeat (3) tick();
      chk("idle_err_hold", 8'(err_count), 8'd7);
      chk("idle_first_hold", 8'(first_err_vec), 8'd1);

      run(2'b11, 5, 1'b0);
      run(2'b11, 3, 1'b0);

      run(2'b00, 0, 1'b1);

      // Abort a failing run with reset during vector 4.
      mode     = 4;
      func_sel = 2'b01;
      start    = 1'b1;
      tick();
      start = 1'b0;
      dc0   = done_cnt;
      repeat (4 * H + 1) tick();
      chk("mid_vec", 8'({a, b, c}), 8'd4);
      chk("mid_err", 8'(err_count), 8'd3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_abc", 8'({a, b, c}), 8'd0);
      chk("abort_busy", 8'(busy), 8'd0);
      chk("abort_err", 8'(err_count), 8'd0);
      chk("abort_pass", 8'(pass), 8'd0);
      chk("abort_first", 8'(first_err_vec), 8'd0);
      repeat (8 * H + 4) tick();
      chk("abort_no_done", 8'(done_cnt - dc0), 8'd0);
      chk("abort_idle", 8'(busy), 8'd0);

      run(2'b10, 6, 1'b0);
      run(2'b10, 2, 1'b0);

      chk("sb_drained", 8'(sb_q.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
